// File: rtl/alu_issue_if.sv
// Decode-to-execute issue bus: instruction/operand inputs, write-back bypass, flush and the ALU-facing outputs.
interface alu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs_data;
  logic [31:0] in_rt_data;
  logic        fwd_valid;
  logic [4:0]  fwd_dest;
  logic [31:0] fwd_data;
  logic        flush;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [3:0]  operation;
  logic [4:0]  shamt;
  logic [4:0]  out_dest;
  logic        out_wen;
  logic        out_illegal;

  // master: decode side plus execute-side ready; slave: the issue register
  modport master (
    output in_valid, in_instr, in_rs_data, in_rt_data,
           fwd_valid, fwd_dest, fwd_data, flush, out_ready,
    input  in_ready, out_valid, op1, op2, operation, shamt,
           out_dest, out_wen, out_illegal
  );
  modport slave (
    input  in_valid, in_instr, in_rs_data, in_rt_data,
           fwd_valid, fwd_dest, fwd_data, flush, out_ready,
    output in_ready, out_valid, op1, op2, operation, shamt,
           out_dest, out_wen, out_illegal
  );
endinterface

// File: rtl/alu_issue.sv
// Execute-stage issue register: decodes a MIPS word into ALU operation/operands,
// applies write-back forwarding and holds the result under a valid/ready handshake.
module alu_issue #(
  parameter bit FWD_EN = 1'b1
) (
  input logic   clk,
  input logic   rst_n,
  alu_issue_if.slave bus
);

  localparam logic [3:0] OP_ADDU = 4'h0, OP_LUI  = 4'h1, OP_SLT  = 4'h2, OP_OR   = 4'h3,
                         OP_ADD  = 4'h4, OP_AND  = 4'h5, OP_SUBU = 4'h6, OP_SUB  = 4'h7,
                         OP_SLL  = 4'h8, OP_SRL  = 4'h9, OP_SLTU = 4'hA, OP_NOR  = 4'hB,
                         OP_PASS = 4'hC;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  operation;
    logic [4:0]  shamt;
    logic [4:0]  dest;
    logic        wen;
    logic        illegal;
  } issue_t;

  logic [5:0]  opc, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] rsv, rtv, imm_se, imm_ze;
  issue_t      iss_d, iss_q;
  logic        vld_q;
  logic        in_ready;

  assign opc    = bus.in_instr[31:26];
  assign rs     = bus.in_instr[25:21];
  assign rt     = bus.in_instr[20:16];
  assign rd     = bus.in_instr[15:11];
  assign funct  = bus.in_instr[5:0];
  assign imm_se = {{16{bus.in_instr[15]}}, bus.in_instr[15:0]};
  assign imm_ze = {16'h0, bus.in_instr[15:0]};

  // r0 wins over the bypass so a stray write to r0 can never leak in
  always_comb begin
    rsv = bus.in_rs_data;
    rtv = bus.in_rt_data;
    if (rs == 5'd0)
      rsv = '0;
    else if (FWD_EN && bus.fwd_valid && bus.fwd_dest == rs)
      rsv = bus.fwd_data;
    if (rt == 5'd0)
      rtv = '0;
    else if (FWD_EN && bus.fwd_valid && bus.fwd_dest == rt)
      rtv = bus.fwd_data;
  end

  always_comb begin
    iss_d         = '0;
    iss_d.illegal = 1'b1;
    case (opc)
      6'h00: begin
        iss_d.illegal = 1'b0;
        iss_d.dest    = rd;
        iss_d.wen     = 1'b1;
        iss_d.op1     = rsv;
        iss_d.op2     = rtv;
        case (funct)
          6'h21: iss_d.operation = OP_ADDU;
          6'h20: iss_d.operation = OP_ADD;
          6'h24: iss_d.operation = OP_AND;
          6'h25: iss_d.operation = OP_OR;
          6'h27: iss_d.operation = OP_NOR;
          6'h2A: iss_d.operation = OP_SLT;
          6'h2B: iss_d.operation = OP_SLTU;
          // ALU subtracts op2-op1, so swap to get rs-rt
          6'h23, 6'h22: begin
            iss_d.operation = (funct == 6'h23) ? OP_SUBU : OP_SUB;
            iss_d.op1       = rtv;
            iss_d.op2       = rsv;
          end
          6'h00, 6'h02: begin
            iss_d.operation = (funct == 6'h00) ? OP_SLL : OP_SRL;
            iss_d.op1       = '0;
            iss_d.shamt     = bus.in_instr[10:6];
          end
          6'h08: begin
            iss_d.operation = OP_PASS;
            iss_d.op1       = '0;
            iss_d.op2       = rsv;
            iss_d.wen       = 1'b0;
          end
          default: begin
            iss_d         = '0;
            iss_d.illegal = 1'b1;
          end
        endcase
      end
      6'h09, 6'h08, 6'h0A, 6'h0B, 6'h23, 6'h2B: begin
        iss_d.illegal = 1'b0;
        iss_d.dest    = rt;
        iss_d.wen     = (opc != 6'h2B);
        iss_d.op1     = rsv;
        iss_d.op2     = imm_se;
        case (opc)
          6'h08:   iss_d.operation = OP_ADD;
          6'h0A:   iss_d.operation = OP_SLT;
          6'h0B:   iss_d.operation = OP_SLTU;
          default: iss_d.operation = OP_ADDU;
        endcase
      end
      6'h0C, 6'h0D: begin
        iss_d.illegal   = 1'b0;
        iss_d.dest      = rt;
        iss_d.wen       = 1'b1;
        iss_d.op1       = rsv;
        iss_d.op2       = imm_ze;
        iss_d.operation = (opc == 6'h0C) ? OP_AND : OP_OR;
      end
      6'h0F: begin
        iss_d.illegal   = 1'b0;
        iss_d.dest      = rt;
        iss_d.wen       = 1'b1;
        iss_d.op2       = imm_ze;
        iss_d.operation = OP_LUI;
      end
      6'h04, 6'h05: begin
        iss_d.illegal   = 1'b0;
        iss_d.dest      = rt;
        iss_d.op1       = rtv;
        iss_d.op2       = rsv;
        iss_d.operation = OP_SUBU;
      end
      default: ;
    endcase
  end

  assign in_ready = !vld_q || bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      iss_q <= '0;
    end else if (bus.flush) begin
      vld_q <= 1'b0;
    end else if (in_ready) begin
      vld_q <= bus.in_valid;
      if (bus.in_valid) iss_q <= iss_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = vld_q;
  assign bus.op1         = iss_q.op1;
  assign bus.op2         = iss_q.op2;
  assign bus.operation   = iss_q.operation;
  assign bus.shamt       = iss_q.shamt;
  assign bus.out_dest    = iss_q.dest;
  assign bus.out_wen     = iss_q.wen;
  assign bus.out_illegal = iss_q.illegal;

endmodule
